// File: rtl/dmem_ctrl.sv
// RV32I MEM-stage data memory controller: req/gnt/rvalid handshake, byte lanes, load extension.
// Optional watchdog enabled by defining DMEM_TIMEOUT_EN (timeout_err tied 0 otherwise).
module dmem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_mem,
    input  logic        store_mem,
    input  logic [2:0]  funct3_mem,
    input  logic [31:0] addr_mem,
    input  logic [31:0] store_data_mem,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        stall_mem,
    output logic [31:0] dm_data_mem,
    output logic        access_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q;
    logic        dm_req_q, dm_we_q, access_err_q;
    logic [31:0] dm_addr_q, dm_wdata_q, dm_data_q;
    logic [3:0]  dm_be_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic        legal_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Decode legality and lane steering of the access currently presented by ex_mem
    always_comb begin
        legal_d = 1'b0;
        be_d    = 4'b1111;
        wdata_d = 32'd0;
        if (load_mem && !store_mem) begin
            case (funct3_mem)
                3'd0, 3'd4: legal_d = 1'b1;
                3'd1, 3'd5: legal_d = ~addr_mem[0];
                3'd2:       legal_d = (addr_mem[1:0] == 2'b00);
                default:    legal_d = 1'b0;
            endcase
        end else if (store_mem && !load_mem) begin
            case (funct3_mem)
                3'd0: begin
                    legal_d = 1'b1;
                    be_d    = 4'b0001 << addr_mem[1:0];
                    wdata_d = {4{store_data_mem[7:0]}};
                end
                3'd1: begin
                    legal_d = ~addr_mem[0];
                    be_d    = 4'b0011 << addr_mem[1:0];
                    wdata_d = {2{store_data_mem[15:0]}};
                end
                3'd2: begin
                    legal_d = (addr_mem[1:0] == 2'b00);
                    wdata_d = store_data_mem;
                end
                default: legal_d = 1'b0;
            endcase
        end
    end

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] wd_q;
    logic       timeout_err_q;
    logic       expire_d;
    assign expire_d    = (wd_q + 8'd1) >= 8'(TIMEOUT_CYCLES);
    assign timeout_err = timeout_err_q;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= 32'd0;
            dm_be_q      <= 4'd0;
            dm_wdata_q   <= 32'd0;
            dm_data_q    <= 32'd0;
            access_err_q <= 1'b0;
            f3_q         <= 3'd0;
            lane_q       <= 2'd0;
`ifdef DMEM_TIMEOUT_EN
            wd_q          <= 8'd0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            access_err_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            timeout_err_q <= 1'b0;
            if (state_q == S_REQ || state_q == S_WAIT) wd_q <= wd_q + 8'd1;
`endif
            case (state_q)
                S_IDLE: begin
                    if (legal_d) begin
                        dm_req_q   <= 1'b1;
                        dm_we_q    <= store_mem;
                        dm_addr_q  <= {addr_mem[31:2], 2'b00};
                        dm_be_q    <= be_d;
                        dm_wdata_q <= wdata_d;
                        f3_q       <= funct3_mem;
                        lane_q     <= addr_mem[1:0];
                        state_q    <= S_REQ;
`ifdef DMEM_TIMEOUT_EN
                        wd_q       <= 8'd0;
`endif
                    end else if (load_mem || store_mem) begin
                        access_err_q <= 1'b1;
                        dm_data_q    <= 32'd0;
                    end
                end
                S_REQ: begin
                    if (dm_gnt) begin
                        dm_req_q <= 1'b0;
                        state_q  <= dm_we_q ? S_DONE : S_WAIT;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (expire_d) begin
                        dm_req_q      <= 1'b0;
                        dm_data_q     <= 32'd0;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_DONE;
                    end
`endif
                end
                S_WAIT: begin
                    if (dm_rvalid) begin
                        dm_data_q <= load_extend(f3_q, lane_q, dm_rdata);
                        state_q   <= S_DONE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (expire_d) begin
                        dm_data_q     <= 32'd0;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_DONE;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall_mem   = ((state_q == S_IDLE) && legal_d) || (state_q == S_REQ) || (state_q == S_WAIT);
    assign dm_req      = dm_req_q;
    assign dm_we       = dm_we_q;
    assign dm_addr     = dm_addr_q;
    assign dm_be       = dm_be_q;
    assign dm_wdata    = dm_wdata_q;
    assign dm_data_mem = dm_data_q;
    assign access_err  = access_err_q;

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Memory-stage data memory controller for the RV32I 5-stage pipeline. Sits between the ex_mem pipeline register and a variable-latency data memory with a req/gnt/rvalid handshake. Generates byte enables and write-data lane steering, and sign/zero-extends load data for mem_wb. Asserts a pipeline stall to the hazards unit until each access completes.

Parameters:
TIMEOUT_CYCLES, 16, watchdog limit in cycles spent in REQ+WAIT; used only with DMEM_TIMEOUT_EN; legal range 2..255.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, synchronous, active-low
load_mem  input  1  MEM-stage instruction is a load
store_mem  input  1  MEM-stage instruction is a store
funct3_mem  input  3  RV32I funct3 of the MEM-stage access
addr_mem  input  32  byte address from the ALU
store_data_mem  input  32  rs2 data for stores
dm_req  output  1  memory request
dm_we  output  1  1 = write, 0 = read
dm_addr  output  32  word-aligned address, addr_mem with [1:0] forced to 0
dm_be  output  4  byte enables
dm_wdata  output  32  lane-steered write data
dm_gnt  input  1  memory accepted the request
dm_rvalid  input  1  read data valid
dm_rdata  input  32  read data word
stall_mem  output  1  freeze if_id/id_ex/ex_mem; bubble into mem_wb
dm_data_mem  output  32  extended load data to mem_wb
access_err  output  1  one-cycle misalignment or illegal-access flag
timeout_err  output  1  one-cycle watchdog flag; constant 0 without DMEM_TIMEOUT_EN

Behaviour:
- Reset: the block has one clock (clk) and a synchronous, active-low reset (rst_n).
- Reset values (rst_n sampled low at a clk edge): state=IDLE; dm_req=0, dm_we=0, dm_addr=0, dm_be=0, dm_wdata=0, dm_data_mem=0, access_err=0, timeout_err=0, watchdog=0.
- stall_mem is combinational: 1 when (IDLE and a legal access is present) or state is REQ or WAIT. Otherwise 0.
- Legal access: exactly one of load_mem/store_mem is set.
  - Loads allow funct3 in {0,1,2,4,5}; stores allow funct3 in {0,1,2}.
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
- Illegal access (both flags set, bad funct3, or misaligned):
  - No request is issued and no stall.
  - access_err=1 for one cycle and dm_data_mem=0.
  - The pipeline advances, and the trap is handled upstream.
- FSM:
  - IDLE: on a legal access, register dm_addr/dm_we/dm_be/dm_wdata and go to REQ.
  - REQ: dm_req=1 with all outputs held stable until dm_gnt=1. On gnt, a store goes to DONE and a load goes to WAIT.
  - WAIT: dm_req=0. On dm_rvalid, capture the extended dm_rdata into dm_data_mem and go to DONE. dm_rvalid is ignored in every other state.
  - DONE: stall_mem=0 and dm_data_mem is held valid; go to IDLE unconditionally. The pipeline advances on this edge, so the same instruction is never re-issued.
- Minimum latency:
  - Store: 2 stall cycles (IDLE, REQ with gnt).
  - Load: 3 stall cycles (IDLE, REQ with gnt, WAIT with rvalid).
- Byte enables:
  - sb: 4'b0001 << addr[1:0], with byte replicated on all 4 lanes.
  - sh: 4'b0011 << addr[1:0], with halfword replicated on both halves.
  - sw: 4'b1111.
  - Loads drive dm_be=4'b1111.
- Load extract:
  - lb/lbu: byte at lane addr[1:0], sign- or zero-extended.
  - lh/lhu: halfword at addr[1], sign- or zero-extended.
  - lw: full word.
- Reset mid-transaction returns to IDLE and drops dm_req the following cycle. The data memory shares rst_n, so stale rvalid cannot occur.
- Inputs from ex_mem are stable while stall_mem=1. The controller latches the access in IDLE regardless.

Optional Feature:
DMEM_TIMEOUT_EN
- Defined:
  - An 8-bit watchdog clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: go to DONE, dm_req=0, dm_data_mem=0, timeout_err=1 for one cycle.
  - A late rvalid after that is ignored.
- Undefined: no counter; REQ and WAIT wait indefinitely; timeout_err tied 0.

Test Plan:
- sw addr=0x100 data=0xDEADBEEF, gnt on first REQ cycle -> dm_be=1111, dm_wdata=0xDEADBEEF, dm_we=1, stall_mem high exactly 2 cycles.
- sb addr=0x103 data=0x000000A5 -> dm_addr=0x100, dm_be=1000, dm_wdata=0xA5A5A5A5.
- lb addr=0x202, gnt delayed 3 cycles, rvalid 2 cycles later with rdata=0x12F0_3456 -> dm_data_mem=0xFFFFFFF0; stall spans 1+4+2 cycles; dm_req held stable through REQ.
- lhu addr=0x202, rdata=0x8001_0000 -> dm_data_mem=0x00008001; lh -> 0xFFFF8001.
- lw addr=0x101 -> no dm_req, access_err pulse, stall_mem=0; load+store both set -> access_err.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never asserted -> timeout_err after 4 REQ cycles, dm_data_mem=0, FSM back in IDLE; also rst_n low in WAIT -> IDLE, dm_req=0 next cycle.
